// File: rtl/unary_stream_gen_pkg.sv
// -----------------------------------------------------------------------------
// unary_pkg
// Shared types and elaboration helpers for the unary bitstream generator:
//   mode_e            stream coding (temporal counter or rate-coded LFSR)
//   ustream_state_e   controller states IDLE / RUN / DRAIN
//   lfsr_taps()       maximal-length Fibonacci tap masks for widths 4..16
//   ustream_cfg_ok()  parameter legality (WIDTH in 4..16, SEED non-zero)
// -----------------------------------------------------------------------------
package unary_pkg;

  typedef enum logic {
    MODE_TEMPORAL = 1'b0,
    MODE_RATE     = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    USTREAM_IDLE  = 2'd0,
    USTREAM_RUN   = 2'd1,
    USTREAM_DRAIN = 2'd2
  } ustream_state_e;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 16;

  // Feedback masks (bit k = register bit k) for a left-shifting Fibonacci LFSR.
  // Each mask is a primitive polynomial, so a non-zero state visits every
  // value 1..2^width-1 exactly once per period.
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // The seed must be non-zero within the register width, otherwise the LFSR
  // locks up at zero and the rate stream loses its exact-count property.
  function automatic bit ustream_cfg_ok(input int unsigned width, input int unsigned seed);
    if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
    return (seed & ((32'd1 << width) - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/unary_stream_gen_if.sv
// -----------------------------------------------------------------------------
// unary_stream_gen_if
// Control, operand and stream signals of unary_stream_gen.
//   master: start, mode, en, in driven; busy, stream_out, valid_out, done seen
//   slave : the generator side
// Optional UNARY_STREAM_POPCNT_EN adds cnt_out (per-channel 1s counters).
// -----------------------------------------------------------------------------
interface unary_stream_gen_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 16
);

  logic                               start;
  logic                               mode;
  logic                               en;
  logic [CHANNELS-1:0][WIDTH-1:0]     in;
  logic                               busy;
  logic [CHANNELS-1:0]                stream_out;
  logic                               valid_out;
  logic                               done;
`ifdef UNARY_STREAM_POPCNT_EN
  logic [CHANNELS-1:0][WIDTH:0]       cnt_out;

  modport master (
    output start, mode, en, in,
    input  busy, stream_out, valid_out, done, cnt_out
  );

  modport slave (
    input  start, mode, en, in,
    output busy, stream_out, valid_out, done, cnt_out
  );
`else
  modport master (
    output start, mode, en, in,
    input  busy, stream_out, valid_out, done
  );

  modport slave (
    input  start, mode, en, in,
    output busy, stream_out, valid_out, done
  );
`endif

endinterface

// File: rtl/unary_stream_gen_lfsr.sv
// -----------------------------------------------------------------------------
// lfsr_rng
// WIDTH-bit maximal-length Fibonacci LFSR used as the rate-mode comparison
// sequence.
//   clk, rst  clock and synchronous active-high reset (state <= seed)
//   load      reload state with seed (takes priority over step)
//   step      advance one position
//   seed      reload value, must be non-zero
//   state     current LFSR value
// -----------------------------------------------------------------------------
module lfsr_rng
  import unary_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state
);

  localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic feedback;

  assign feedback = ^(state & TAPS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= seed;
    end else if (step) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/unary_stream_gen.sv
// -----------------------------------------------------------------------------
// unary_stream_gen
// Multi-channel unary bitstream generator. A start in IDLE latches CHANNELS
// operands and the coding mode, then one stream bit per channel is produced
// for each of the 2^WIDTH enabled RUN cycles: stream_out[i] = in_q[i] > rng.
// rng is the index itself (temporal / thermometer) or 0 followed by the LFSR
// sequence (rate). Either way every value 0..2^WIDTH-1 is compared exactly
// once, so channel i emits exactly in_q[i] ones per stream.
//   clk, rst       clock, synchronous active-high reset
//   bus (slave)    start, mode, en, in -> busy, stream_out, valid_out, done
// Optional feature macro: UNARY_STREAM_POPCNT_EN adds bus.cnt_out, the
// per-channel count of emitted 1s, cleared on an accepted start.
// -----------------------------------------------------------------------------
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned SEED     = 1
) (
  input  logic               clk,
  input  logic               rst,
  unary_stream_gen_if.slave  bus
);

  if (!ustream_cfg_ok(WIDTH, SEED)) begin : g_cfg_check
    $error("unary_stream_gen: WIDTH must be within 4..16 and SEED must be non-zero");
  end

  localparam logic [1:0]       ST_IDLE  = USTREAM_IDLE;
  localparam logic [1:0]       ST_RUN   = USTREAM_RUN;
  localparam logic [1:0]       ST_DRAIN = USTREAM_DRAIN;
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] IDX_LAST = '1;

  logic [1:0]                     state_q;
  mode_e                          mode_q;
  logic [CHANNELS-1:0][WIDTH-1:0] in_q;
  logic [WIDTH-1:0]               idx_q;
  logic [CHANNELS-1:0]            stream_q;
  logic                           valid_q;
  logic                           done_q;

  logic                           accept;
  logic                           run_step;
  logic                           lfsr_step;
  logic [WIDTH-1:0]               lfsr_state;
  logic [WIDTH-1:0]               rng;
  logic [CHANNELS-1:0]            cmp;

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign run_step = (state_q == ST_RUN) && bus.en;

  // The rate stream compares 0 first and then the LFSR values, so the LFSR
  // only moves once idx has left zero; it therefore reads SEED at idx = 1.
  assign lfsr_step = run_step && (mode_q == MODE_RATE) && (idx_q != '0);
  assign rng       = ((mode_q == MODE_RATE) && (idx_q != '0)) ? lfsr_state : idx_q;

  lfsr_rng #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (lfsr_step),
    .seed  (SEED_W),
    .state (lfsr_state)
  );

  // NOTE: a combinational block assigns a default to every output before any
  // conditional update so no path leaves a value held, which would infer a latch.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cmp[i] = in_q[i] > rng;
    end
  end

  // NOTE: the operand bank in_q is reset along with the control flops because
  // an aborted run must leave no operand behind; plain data stores without
  // that need are usually left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_TEMPORAL;
      in_q     <= '0;
      idx_q    <= '0;
      stream_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= run_step;
      done_q  <= run_step && (idx_q == IDX_LAST);
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_RUN;
            mode_q  <= mode_e'(bus.mode);
            in_q    <= bus.in;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            stream_q <= cmp;
            idx_q    <= idx_q + WIDTH'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.stream_out = stream_q;
  assign bus.valid_out  = valid_q;
  assign bus.done       = done_q;

`ifdef UNARY_STREAM_POPCNT_EN
  // Counts follow the registered stream, so the last increment lands with the
  // DRAIN edge and the totals are final from the cycle after done.
  logic [CHANNELS-1:0][WIDTH:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt_q <= '0;
    end else if (valid_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (stream_q[i]) begin
          cnt_q[i] <= cnt_q[i] + (WIDTH + 1)'(1);
        end
      end
    end
  end

  assign bus.cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_unary_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_unary_stream_gen
// Self-checking bench for unary_stream_gen. Instance A: WIDTH=8, CHANNELS=16;
// instance B: WIDTH=4, CHANNELS=4. Expected streams come from the arithmetic
// rules of the block (thermometer: bit p = operand > p; rate: exact 1s count,
// each threshold used once, reproducible from SEED).
// Honours UNARY_STREAM_POPCNT_EN for the cnt_out checks.
// -----------------------------------------------------------------------------
module tb_unary_stream_gen;
  import unary_pkg::*;

  localparam int W       = 8;
  localparam int CH      = 16;
  localparam int N       = 1 << W;
  localparam int WB      = 4;
  localparam int CHB     = 4;
  localparam int MAX_CYC = 590;

  typedef logic [CH-1:0][W-1:0] ops_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  unary_stream_gen_if #(.WIDTH(W),  .CHANNELS(CH))  bus_a ();
  unary_stream_gen_if #(.WIDTH(WB), .CHANNELS(CHB)) bus_b ();

  unary_stream_gen #(.WIDTH(W),  .CHANNELS(CH),  .SEED(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  unary_stream_gen #(.WIDTH(WB), .CHANNELS(CHB), .SEED(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [CH-1:0] cap_bits [N];
  logic [CH-1:0] ref_bits [N];
  logic          cap_valid_hist [MAX_CYC + 2];
  int            cap_n, cap_done_cyc, cap_done_cnt, cap_idle_cyc, cap_first_valid;

  function automatic ops_t rand_ops();
    ops_t o;
    for (int i = 0; i < CH; i++) o[i] = W'($urandom_range(0, N - 1));
    return o;
  endfunction

  function automatic logic [CH-1:0] therm_vec(input ops_t ops, input int p);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = (int'(ops[i]) > p);
    return v;
  endfunction

  function automatic int ones_on(input int ch);
    int c = 0;
    for (int p = 0; p < cap_n && p < N; p++) if (cap_bits[p][ch]) c++;
    return c;
  endfunction

  // Launch one stream on instance A from an IDLE negedge and record it until
  // the first IDLE cycle. Cycle 0 is the start cycle; en is low on cycles
  // st_lo..st_hi. With noise set, start, mode and in are scrambled on every
  // busy cycle. Returns at the negedge of the first IDLE cycle.
  task automatic run_a(input ops_t ops, input logic md, input int st_lo,
                       input int st_hi, input bit noise);
    int cyc = 0;
    cap_n = 0; cap_done_cyc = -1; cap_done_cnt = 0; cap_idle_cyc = -1; cap_first_valid = -1;
    for (int k = 0; k < MAX_CYC + 2; k++) cap_valid_hist[k] = 1'b0;
    bus_a.start = 1'b1; bus_a.mode = md; bus_a.in = ops; bus_a.en = 1'b1;
    while (cap_idle_cyc < 0 && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (bus_a.valid_out) begin
        if (cap_n < N) cap_bits[cap_n] = bus_a.stream_out;
        cap_n++;
        if (cap_first_valid < 0) cap_first_valid = cyc;
        cap_valid_hist[cyc] = 1'b1;
      end
      if (bus_a.done) begin
        cap_done_cnt++;
        cap_done_cyc = cyc;
      end
      if (!bus_a.busy) begin
        cap_idle_cyc = cyc;
      end else begin
        bus_a.en = !(cyc >= st_lo && cyc <= st_hi);
        if (noise) begin
          bus_a.start = 1'b1; bus_a.mode = ~md; bus_a.in = rand_ops();
        end else begin
          bus_a.start = 1'b0;
        end
      end
    end
    bus_a.start = 1'b0; bus_a.en = 1'b1;
    n_cmp++;
    if (cap_idle_cyc < 0) begin
      n_bad++;
      $display("FAIL run_timeout: no return to IDLE within %0d cycles", MAX_CYC);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.en = 1'b0; bus_a.in = '0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.en = 1'b0; bus_b.in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus_a.busy, bus_a.valid_out, bus_a.done, bus_a.stream_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: busy/valid/done/stream=%b required all 0",
               {bus_a.busy, bus_a.valid_out, bus_a.done, bus_a.stream_out});
    end
    n_cmp++;
    if ({bus_b.busy, bus_b.valid_out, bus_b.done, bus_b.stream_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: busy/valid/done/stream=%b required all 0",
               {bus_b.busy, bus_b.valid_out, bus_b.done, bus_b.stream_out});
    end
`ifdef UNARY_STREAM_POPCNT_EN
    n_cmp++;
    if (bus_a.cnt_out !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: cnt_out=%h required 0", bus_a.cnt_out);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_a.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b required 0", bus_a.busy);
    end
  endtask

  task automatic test_temporal_w4();
    logic [15:0]           seq = '0;
    logic [CHB-1:0][WB-1:0] opsb;
    int nvalid = 0, done_cyc = -1, idle_cyc = -1, errs = 0;
    int ones [CHB];
    for (int i = 0; i < CHB; i++) ones[i] = 0;
    opsb[0] = 4'd0; opsb[1] = 4'd5; opsb[2] = 4'd15; opsb[3] = 4'd8;
    bus_b.start = 1'b1; bus_b.mode = MODE_TEMPORAL; bus_b.in = opsb; bus_b.en = 1'b1;
    for (int cyc = 1; cyc <= 30 && idle_cyc < 0; cyc++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      if (bus_b.valid_out) begin
        for (int i = 0; i < CHB; i++) begin
          if (bus_b.stream_out[i] !== (int'(opsb[i]) > nvalid)) errs++;
          if (bus_b.stream_out[i]) ones[i]++;
        end
        seq = {seq[14:0], bus_b.stream_out[1]};
        nvalid++;
      end
      if (bus_b.done) done_cyc = cyc;
      if (!bus_b.busy) idle_cyc = cyc;
    end
    n_cmp++;
    if (nvalid != 16) begin n_bad++; $display("FAIL w4_valid_count: got %0d required 16", nvalid); end
    n_cmp++;
    if (done_cyc != 17) begin n_bad++; $display("FAIL w4_done_cycle: got %0d required 17", done_cyc); end
    n_cmp++;
    if (idle_cyc != 18) begin n_bad++; $display("FAIL w4_idle_cycle: got %0d required 18", idle_cyc); end
    n_cmp++;
    if (seq !== 16'b1111_1000_0000_0000) begin
      n_bad++; $display("FAIL w4_ch1_seq: got %b required 1111100000000000", seq);
    end
    n_cmp++;
    if (errs != 0) begin n_bad++; $display("FAIL w4_thermometer: %0d bad bits required 0", errs); end
    for (int i = 0; i < CHB; i++) begin
      n_cmp++;
      if (ones[i] != int'(opsb[i])) begin
        n_bad++; $display("FAIL w4_ones_ch%0d: got %0d required %0d", i, ones[i], opsb[i]);
      end
    end
  endtask

  task automatic test_temporal();
    ops_t ops = rand_ops();
    int errs = 0, first_bad = -1;
    ops[0] = '0; ops[1] = '1;
    run_a(ops, MODE_TEMPORAL, -1, -1, 1'b0);
    n_cmp++;
    if (cap_first_valid != 2) begin n_bad++; $display("FAIL t8_first_valid: got %0d required 2", cap_first_valid); end
    n_cmp++;
    if (cap_n != N) begin n_bad++; $display("FAIL t8_valid_count: got %0d required %0d", cap_n, N); end
    n_cmp++;
    if (cap_done_cyc != N + 1 || cap_done_cnt != 1) begin
      n_bad++; $display("FAIL t8_done: cycle %0d count %0d required cycle %0d count 1", cap_done_cyc, cap_done_cnt, N + 1);
    end
    n_cmp++;
    if (cap_idle_cyc != N + 2) begin n_bad++; $display("FAIL t8_idle_cycle: got %0d required %0d", cap_idle_cyc, N + 2); end
    for (int p = 0; p < N && p < cap_n; p++) begin
      if (cap_bits[p] !== therm_vec(ops, p)) begin
        errs++;
        if (first_bad < 0) first_bad = p;
      end
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++; $display("FAIL t8_stream: %0d bad positions (first %0d) required 0", errs, first_bad);
    end
  endtask

  task automatic test_stall();
    ops_t ops = rand_ops();
    int errs = 0, gap = 0;
    run_a(ops, MODE_TEMPORAL, 5, 9, 1'b0);
    for (int c = 6; c <= 10; c++) if (cap_valid_hist[c]) gap++;
    n_cmp++;
    if (gap != 0 || !cap_valid_hist[5] || !cap_valid_hist[11]) begin
      n_bad++; $display("FAIL stall_gap: %0d valids in 6..10, v5=%b v11=%b required 0,1,1",
                        gap, cap_valid_hist[5], cap_valid_hist[11]);
    end
    n_cmp++;
    if (cap_done_cyc != N + 6) begin n_bad++; $display("FAIL stall_done: got %0d required %0d", cap_done_cyc, N + 6); end
    n_cmp++;
    if (cap_n != N) begin n_bad++; $display("FAIL stall_count: got %0d required %0d", cap_n, N); end
    for (int p = 0; p < N && p < cap_n; p++) if (cap_bits[p] !== therm_vec(ops, p)) errs++;
    n_cmp++;
    if (errs != 0) begin n_bad++; $display("FAIL stall_temporal_stream: %0d bad positions required 0", errs); end
    // Rate mode: a stalled stream must equal the unstalled one bit for bit.
    ops = rand_ops();
    run_a(ops, MODE_RATE, -1, -1, 1'b0);
    for (int p = 0; p < N; p++) ref_bits[p] = cap_bits[p];
    run_a(ops, MODE_RATE, 5, 9, 1'b0);
    errs = 0;
    for (int p = 0; p < N && p < cap_n; p++) if (cap_bits[p] !== ref_bits[p]) errs++;
    n_cmp++;
    if (errs != 0 || cap_n != N) begin
      n_bad++; $display("FAIL stall_rate_stream: %0d differing positions, %0d bits, required 0 and %0d", errs, cap_n, N);
    end
  endtask

  task automatic test_start_ignored();
    ops_t ops = rand_ops();
    int errs = 0;
    run_a(ops, MODE_TEMPORAL, -1, -1, 1'b1);
    for (int p = 0; p < N && p < cap_n; p++) if (cap_bits[p] !== therm_vec(ops, p)) errs++;
    n_cmp++;
    if (errs != 0 || cap_n != N) begin
      n_bad++; $display("FAIL noise_stream: %0d bad positions, %0d bits, required 0 and %0d", errs, cap_n, N);
    end
    n_cmp++;
    if (cap_done_cyc != N + 1 || cap_idle_cyc != N + 2) begin
      n_bad++; $display("FAIL noise_timing: done %0d idle %0d required %0d %0d", cap_done_cyc, cap_idle_cyc, N + 1, N + 2);
    end
  endtask

  task automatic test_back_to_back();
    ops_t ops = rand_ops();
    int errs = 0;
    run_a(ops, MODE_RATE, -1, -1, 1'b0);
    n_cmp++;
    if (cap_first_valid != 2 || cap_done_cyc != N + 1) begin
      n_bad++; $display("FAIL b2b_timing: first valid %0d done %0d required 2 %0d", cap_first_valid, cap_done_cyc, N + 1);
    end
    for (int i = 0; i < CH; i++) if (ones_on(i) != int'(ops[i])) errs++;
    n_cmp++;
    if (errs != 0) begin n_bad++; $display("FAIL b2b_counts: %0d channels off required 0", errs); end
  endtask

  task automatic test_rate_coverage();
    int perm [N];
    int zeros [N];
    int seen [N];
    int errs = 0, bad_seen = 0, rng;
    ops_t ops;
    for (int v = 0; v < N; v++) begin perm[v] = v; zeros[v] = 0; seen[v] = 0; end
    for (int v = N - 1; v > 0; v--) begin
      int j = $urandom_range(0, v);
      int t = perm[v];
      perm[v] = perm[j]; perm[j] = t;
    end
    for (int r = 0; r < N / CH; r++) begin
      for (int i = 0; i < CH; i++) ops[i] = W'(perm[r * CH + i]);
      run_a(ops, MODE_RATE, -1, -1, 1'b0);
      for (int i = 0; i < CH; i++) begin
        n_cmp++;
        if (ones_on(i) != int'(ops[i])) begin
          n_bad++; $display("FAIL rate_ones run%0d ch%0d: got %0d required %0d", r, i, ones_on(i), ops[i]);
        end
      end
      for (int p = 0; p < N && p < cap_n; p++)
        for (int i = 0; i < CH; i++) if (!cap_bits[p][i]) zeros[p]++;
    end
    // With every operand 0..N-1 applied once, position p shows a 0 for
    // exactly rng+1 operands, which recovers the threshold used there.
    for (int p = 0; p < N; p++) begin
      rng = zeros[p] - 1;
      if (rng >= 0 && rng < N) seen[rng]++;
      else errs++;
    end
    n_cmp++;
    if (zeros[0] != 1) begin n_bad++; $display("FAIL rate_first_rng: got %0d required 0", zeros[0] - 1); end
    for (int v = 0; v < N; v++) if (seen[v] != 1) bad_seen++;
    n_cmp++;
    if (bad_seen != 0 || errs != 0) begin
      n_bad++; $display("FAIL rate_coverage: %0d thresholds not seen once, %0d out of range, required 0", bad_seen, errs);
    end
  endtask

  task automatic test_reset_midrun();
    ops_t ops = rand_ops();
    int n = 0, errs = 0, late_done = 0;
    run_a(ops, MODE_RATE, -1, -1, 1'b0);
    for (int p = 0; p < N; p++) ref_bits[p] = cap_bits[p];
    bus_a.start = 1'b1; bus_a.mode = MODE_RATE; bus_a.in = ops; bus_a.en = 1'b1;
    for (int cyc = 1; cyc <= 101; cyc++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      if (bus_a.valid_out) begin
        if (n < N && bus_a.stream_out !== ref_bits[n]) errs++;
        n++;
      end
      if (cyc == 101) rst = 1'b1;   // idx = 100 in this cycle
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus_a.busy, bus_a.valid_out, bus_a.done, bus_a.stream_out} !== '0) begin
      n_bad++; $display("FAIL midrun_reset_outputs: %b required all 0",
                        {bus_a.busy, bus_a.valid_out, bus_a.done, bus_a.stream_out});
    end
`ifdef UNARY_STREAM_POPCNT_EN
    n_cmp++;
    if (bus_a.cnt_out !== '0) begin n_bad++; $display("FAIL midrun_reset_cnt: %h required 0", bus_a.cnt_out); end
`endif
    n_cmp++;
    if (n != 100 || errs != 0) begin
      n_bad++; $display("FAIL midrun_prefix: %0d bits %0d wrong required 100 and 0", n, errs);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) late_done++;
    end
    n_cmp++;
    if (late_done != 0) begin n_bad++; $display("FAIL midrun_no_done: %0d active cycles required 0", late_done); end
    run_a(ops, MODE_RATE, -1, -1, 1'b0);
    errs = 0;
    for (int p = 0; p < N && p < cap_n; p++) if (cap_bits[p] !== ref_bits[p]) errs++;
    n_cmp++;
    if (errs != 0 || cap_n != N) begin
      n_bad++; $display("FAIL restart_sequence: %0d differing, %0d bits, required 0 and %0d", errs, cap_n, N);
    end
  endtask

`ifdef UNARY_STREAM_POPCNT_EN
  task automatic test_popcnt();
    ops_t ops = rand_ops();
    ops[0] = W'(255); ops[1] = W'(0); ops[2] = W'(128);
    run_a(ops, MODE_RATE, 3, 4, 1'b0);
    for (int i = 0; i < CH; i++) begin
      n_cmp++;
      if (int'(bus_a.cnt_out[i]) != int'(ops[i])) begin
        n_bad++; $display("FAIL popcnt_ch%0d: got %0d required %0d", i, bus_a.cnt_out[i], ops[i]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_temporal_w4();
    test_temporal();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_rate_coverage();
    test_reset_midrun();
`ifdef UNARY_STREAM_POPCNT_EN
    test_popcnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unary_stream_gen.md
# unary_stream_gen

Parametrised multi-channel unary bitstream generator for the temporal-LUT multiplier datapath. It is the successor of the single-shot comparator array. On `start` it latches a vector of binary operands. It then runs a full 2^WIDTH-cycle stream with an internally generated comparison sequence, selectable as a temporal (thermometer) counter or a rate-coded LFSR. It adds stall, completion signalling and exact-count guarantees.

## Interface
- `WIDTH`, 8: operand and RNG width; legal range 4..16.
- `CHANNELS`, 16: number of parallel operands and output bits.
- `SEED`, 1: LFSR reset and reload value; must be non-zero.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high (the clock is `clk`).
- `start`  in  1  launch request; honoured only in IDLE.
- `mode`  in  1  0 = temporal (counter), 1 = rate (LFSR); latched with `start`.
- `en`  in  1  advance enable while running; low stalls the stream.
- `in`  in  CHANNELS×WIDTH  operands, latched with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `stream_out`  out  CHANNELS  registered comparison bits, `in_q[i] > rng`.
- `valid_out`  out  1  `stream_out` carries a stream bit this cycle.
- `done`  out  1  one-cycle pulse coincident with the last `valid_out`.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN when `start`=1. In that cycle: latch `in`→`in_q` and `mode`→`mode_q`, clear `idx`, reload the LFSR with SEED.
- RUN: on each cycle with `en`=1:
  - register `stream_out[i] = (in_q[i] > rng)`;
  - set `valid_out`=1 in the next cycle;
  - advance `idx` (WIDTH bits).
- RUN, cycle with `en`=0: `idx`, LFSR and `stream_out` hold; `valid_out`=0 in the next cycle.
- RUN→DRAIN on the enabled cycle with `idx` = 2^WIDTH−1. DRAIN→IDLE unconditionally after one cycle.
- rng, temporal mode: rng = `idx`. The stream is a thermometer code: the first `in_q[i]` valid bits are 1, the rest 0.
- rng, rate mode: rng = 0 when `idx`=0. Otherwise rng = LFSR state, with the LFSR advancing only on enabled cycles where `idx`≠0.
  - The maximal-length Fibonacci LFSR covers 1..2^WIDTH−1 exactly once.
  - Every value 0..2^WIDTH−1 is therefore compared once.
- Guarantee in both modes: the number of 1s on channel i over one stream equals `in_q[i]` exactly. Operand 0 gives all zeros; operand 2^WIDTH−1 gives a single 0.
- Comparison is unsigned.
- `start` while `busy` is ignored, including the DRAIN cycle. `start` and `in` changes during a run have no effect.
- `rst` mid-run:
  - next cycle: IDLE, all outputs 0, LFSR = SEED, `in_q` = 0;
  - no `done` is generated for the aborted stream.

## Timing
- Reset values: `busy`=0, `stream_out`=0, `valid_out`=0, `done`=0.
- With `start` at cycle 0 and `en` held high:
  - `busy` is high in cycles 1..2^WIDTH+1;
  - `valid_out` is high in cycles 2..2^WIDTH+1;
  - `done` is high in cycle 2^WIDTH+1;
  - IDLE is reached in cycle 2^WIDTH+2, and a `start` there is accepted.
- Each stall cycle lengthens the run by one cycle and inserts one `valid_out`=0 gap.
- Latency from an enabled RUN cycle to its `stream_out` bit: 1 cycle.
- `stream_out` holds its last value when `valid_out`=0. Consumers ignore it then.

## Configuration
- `UNARY_STREAM_POPCNT_EN` defined:
  - adds output `cnt_out` (CHANNELS×(WIDTH+1)), per-channel counters of emitted 1s;
  - counters clear on accepted `start` and on `rst`, and increment on `valid_out && stream_out[i]`;
  - the final values are readable from the cycle after `done` until the next accepted `start`.
- Not defined: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `unary_pkg` holds:
  - `mode_e` (MODE_TEMPORAL=0, MODE_RATE=1);
  - state enum `ustream_state_e`;
  - constant function `lfsr_taps(width)` returning maximal-length tap masks for 4..16;
  - an elaboration check that rejects WIDTH outside 4..16 and SEED=0.
- Sub-module `lfsr_rng` provides a WIDTH-bit LFSR with `load`, `step` and `seed` inputs.
- The FSM, the `idx` counter and the comparator array stay in the top module.

## Test plan
- WIDTH=4, temporal, `in`={0,5,15,8}, `en`=1: 16 valid bits; channel 1 reads 1111100000000000; `done` at cycle 17 after `start`.
- WIDTH=8, rate, random operands: the count of 1s per channel equals the operand exactly; every non-zero rng value appears once per stream.
- `en` low for cycles 5..9 of a run: `valid_out` has a 5-cycle gap, the stream content is unchanged, and `done` is 5 cycles later.
- `start` asserted during RUN and during DRAIN with new `in`: ignored, and the current stream is unaffected; `start` in the first IDLE cycle launches a new run.
- `rst` at `idx`=100 in WIDTH=8 rate mode: all outputs 0 in the next cycle, no `done`; a restart reproduces the same LFSR sequence from SEED.
- With `UNARY_STREAM_POPCNT_EN`, `in`={255,0,128}: `cnt_out`={255,0,128} after `done`.
